// File: rtl/spi_dac_defs.sv
// Shared definitions for the multi-channel SPI DAC driver: FSM encoding,
// frame geometry derivations and a constant-evaluable clog2.
package spi_dac_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
    endfunction

    function automatic int frame_w(input int cmd_w, input int data_w);
        return cmd_w + data_w;
    endfunction

    function automatic int t_frame(input int clk_div, input int fw);
        return 32'sd2 * clk_div * fw;
    endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// SCK generator for one SPI frame: a half-period divider plus a bit counter.
// Strobes are phase decodes for the coming CLK edge; qualify them with o_busy.
module spi_bit_timer
    import spi_dac_defs::*;
#(
    parameter int CLK_DIV = 2,
    parameter int FRAME_W = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_start,
    output logic o_busy,
    output logic o_sck,
    output logic o_shift_strobe,
    output logic o_sample_strobe,
    output logic o_last_bit
);

    localparam int PH_W  = cnt_w(32'sd2 * CLK_DIV);
    localparam int BIT_W = cnt_w(FRAME_W);
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(CLK_DIV - 32'sd1);
    localparam logic [PH_W-1:0]  PH_END   = PH_W'(32'sd2 * CLK_DIV - 32'sd1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 32'sd1);

    logic [PH_W-1:0]  r_phase;
    logic [BIT_W-1:0] r_bit;
    logic             r_busy;
    logic             r_sck;

    assign o_busy          = r_busy;
    assign o_sck           = r_sck;
    assign o_sample_strobe = (r_phase == PH_RISE);
    assign o_shift_strobe  = (r_phase == PH_END);
    assign o_last_bit      = (r_bit == BIT_LAST);

    // Phase/bit counters; r_sck is the level for the phase being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_busy  <= 1'b0;
            r_phase <= '0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_phase <= '0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
        end else if (r_busy) begin
            if (r_phase == PH_END) begin
                r_phase <= '0;
                r_sck   <= 1'b0;
                if (r_bit == BIT_LAST) begin
                    r_busy <= 1'b0;
                    r_bit  <= '0;
                end else begin
                    r_bit <= r_bit + BIT_W'(1);
                end
            end else begin
                r_phase <= r_phase + PH_W'(1);
                r_sck   <= (r_phase >= PH_RISE);
            end
        end else begin
            r_phase <= '0;
            r_sck   <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_dac_mc.sv
// Multi-channel SPI DAC driver: latches a sample vector and sends one
// {channel, sample} frame per channel, capturing MISO into rdata per frame.
module spi_dac_mc
    import spi_dac_defs::*;
#(
    parameter int DATA_W  = 16,
    parameter int N_CH    = 2,
    parameter int CMD_W   = 4,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  valid,
    output logic                                  ready,
    input  logic [N_CH*DATA_W-1:0]                value,
    output logic                                  done,
    output logic [frame_w(CMD_W, DATA_W)-1:0]     rdata,
    output logic                                  rvalid,
    output logic                                  CS_n,
    output logic                                  SCK,
    output logic                                  MOSI,
    input  logic                                  MISO
);

    localparam int FRAME_W = frame_w(CMD_W, DATA_W);
    localparam int CH_W    = cnt_w(N_CH);
    localparam int GAP_W   = cnt_w(CS_GAP);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 32'sd1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 32'sd1);

    state_t              r_state;
    logic [DATA_W-1:0]   r_word [N_CH];
    logic [CH_W-1:0]     r_ch;
    logic [GAP_W-1:0]    r_gap;
    logic [FRAME_W-1:0]  r_tx;
    logic [FRAME_W-1:0]  r_rx;
    logic [FRAME_W-1:0]  r_rdata;
    logic                r_cs_n;
    logic                r_ready;
    logic                r_done;
    logic                r_rvalid;

    logic                w_busy;
    logic                w_sck;
    logic                w_shift;
    logic                w_sample;
    logic                w_last;
    logic                w_accept;
    logic                w_gap_end;
    logic                w_start;
    logic                w_frame_end;
    logic [CH_W-1:0]     w_ch_nxt;

    assign w_accept    = (r_state == ST_IDLE) && r_ready && valid;
    assign w_gap_end   = (r_state == ST_GAP) && (r_gap == GAP_LAST);
    assign w_start     = w_accept || w_gap_end;
    assign w_frame_end = (r_state == ST_SHIFT) && w_busy && w_shift && w_last;
    assign w_ch_nxt    = r_ch + CH_W'(1);

    spi_bit_timer #(
        .CLK_DIV (CLK_DIV),
        .FRAME_W (FRAME_W)
    ) u_timer (
        .CLK             (CLK),
        .RST             (RST),
        .i_start         (w_start),
        .o_busy          (w_busy),
        .o_sck           (w_sck),
        .o_shift_strobe  (w_shift),
        .o_sample_strobe (w_sample),
        .o_last_bit      (w_last)
    );

    // Transfer sequencer; the first gap cycle doubles as the end-of-frame cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            for (int c = 0; c < N_CH; c++) begin
                r_word[c] <= '0;
            end
            r_ch     <= '0;
            r_gap    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_rdata  <= '0;
            r_cs_n   <= 1'b1;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        for (int c = 0; c < N_CH; c++) begin
                            r_word[c] <= value[c*DATA_W +: DATA_W];
                        end
                        r_ch    <= '0;
                        r_tx    <= {CMD_W'(0), value[DATA_W-1:0]};
                        r_cs_n  <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_busy && w_sample) begin
                        r_rx <= {r_rx[FRAME_W-2:0], MISO};
                    end else begin
                        r_rx <= r_rx;
                    end
                    if (w_frame_end) begin
                        r_cs_n   <= 1'b1;
                        r_tx     <= '0;
                        r_rdata  <= r_rx;
                        r_rvalid <= 1'b1;
                        if (r_ch == CH_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_gap   <= '0;
                            r_state <= ST_GAP;
                        end
                    end else if (w_busy && w_shift) begin
                        r_tx <= {r_tx[FRAME_W-2:0], 1'b0};
                    end else begin
                        r_tx <= r_tx;
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        r_ch    <= w_ch_nxt;
                        r_tx    <= {CMD_W'(w_ch_nxt), r_word[w_ch_nxt]};
                        r_cs_n  <= 1'b0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cs_n  <= 1'b1;
                    r_tx    <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign CS_n   = r_cs_n;
    assign SCK    = w_sck;
    assign MOSI   = r_tx[FRAME_W-1];

endmodule

// File: tb/tb_spi_dac_mc.sv
// Self-checking bench for spi_dac_mc: default 2-channel instance plus a
// 1-channel, CLK_DIV=1 instance, checked cycle by cycle against a timing model.
module tb_spi_dac_mc;

    localparam int DW  = 16;
    localparam int NC  = 2;
    localparam int CW  = 4;
    localparam int DIV = 2;
    localparam int GAP = 2;
    localparam int FW  = CW + DW;
    localparam int DW1 = 12;
    localparam int FW1 = 13;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                RST;
    logic                valid;
    logic [NC*DW-1:0]    value;
    logic                ready, done, rvalid, CS_n, SCK, MOSI, MISO;
    logic [FW-1:0]       rdata;

    logic                valid1;
    logic [DW1-1:0]      value1;
    logic                ready1, done1, rvalid1, CS_n1, SCK1, MOSI1;
    logic                miso1 = 1'b1;
    logic [FW1-1:0]      rdata1;

    int n_checks = 0;
    int n_fail   = 0;

    spi_dac_mc dut (
        .CLK(CLK), .RST(RST), .valid(valid), .ready(ready), .value(value),
        .done(done), .rdata(rdata), .rvalid(rvalid), .CS_n(CS_n), .SCK(SCK),
        .MOSI(MOSI), .MISO(MISO)
    );

    spi_dac_mc #(
        .DATA_W(DW1), .N_CH(1), .CMD_W(1), .CLK_DIV(1), .CS_GAP(GAP)
    ) dut1 (
        .CLK(CLK), .RST(RST), .valid(valid1), .ready(ready1), .value(value1),
        .done(done1), .rdata(rdata1), .rvalid(rvalid1), .CS_n(CS_n1), .SCK(SCK1),
        .MOSI(MOSI1), .MISO(miso1)
    );

    // MISO slave model: presents bit 0 when CS_n falls, next bit on each SCK fall.
    int sck_falls  = 0;
    int cs_falls   = 0;
    int idx_base   = 0;
    int frame_base = 0;
    int m_idx, m_fr;
    logic [NC-1:0][FW-1:0] miso_pat;

    always @(negedge SCK) sck_falls <= sck_falls + 1;
    always @(negedge CS_n) begin
        cs_falls <= cs_falls + 1;
        idx_base <= sck_falls;
    end
    always_comb begin
        m_idx = sck_falls - idx_base;
        m_fr  = cs_falls - frame_base - 1;
        MISO  = 1'b0;
        if (m_idx >= 0 && m_idx < FW && m_fr >= 0 && m_fr < NC) begin
            MISO = miso_pat[m_fr][FW-1-m_idx];
        end
    end

    // Expected pin behaviour at cycle t after the accept edge (t=0 is accept cycle).
    function automatic void model(input int t, input int n, input int fw, input int div,
                                  input int gap, output logic cs, output logic sck,
                                  output int fr, output int bi, output logic dn, output logic rv);
        int tf, per, last, o;
        tf   = 2 * div * fw;
        per  = tf + gap;
        last = n * tf + (n - 1) * gap + 1;
        cs = 1'b1; sck = 1'b0; fr = -1; bi = -1;
        dn = (t == last);
        rv = (t == last);
        if (t >= 1 && t < last) begin
            fr = (t - 1) / per;
            o  = (t - 1) % per;
            if (o < tf) begin
                cs  = 1'b0;
                bi  = o / (2 * div);
                sck = ((o % (2 * div)) >= div);
            end else if (o == tf) begin
                rv = 1'b1;
            end
        end
        if (t == last) fr = n - 1;
    endfunction

    task automatic test_reset();
        RST = 1'b1; valid = 1'b0; valid1 = 1'b0; value = '0; value1 = '0;
        miso_pat = '0;
        repeat (3) begin
            @(posedge CLK); #1;
            n_checks++;
            if ({CS_n, SCK, MOSI, ready, done, rvalid} !== 6'b100000 || rdata !== '0) begin
                n_fail++;
                $display("FAIL reset_pins: {cs,sck,mosi,rdy,done,rv}=%b rdata=%h, want 100000 rdata=0",
                         {CS_n, SCK, MOSI, ready, done, rvalid}, rdata);
            end
            n_checks++;
            if ({CS_n1, SCK1, MOSI1, ready1, done1, rvalid1} !== 6'b100000) begin
                n_fail++;
                $display("FAIL reset_pins1: got %b want 100000", {CS_n1, SCK1, MOSI1, ready1, done1, rvalid1});
            end
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        n_checks++;
        if ({ready, ready1, CS_n} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_release: {rdy,rdy1,cs}=%b want 111", {ready, ready1, CS_n});
        end
    endtask

    // One full transfer; optionally keeps valid high and swaps value at cycle 10.
    task automatic test_transfer(input logic [NC*DW-1:0] vec, input logic [FW-1:0] p0,
                                 input logic [FW-1:0] p1, input bit pre_accepted,
                                 input bit hold, input logic [NC*DW-1:0] vec_next);
        logic [FW-1:0] fr_exp [NC];
        logic cs, sck, dn, rv, mo;
        int fr, bi, last;
        last = NC * 2 * DIV * FW + (NC - 1) * GAP + 1;
        for (int c = 0; c < NC; c++) fr_exp[c] = {4'(c), vec[c*DW +: DW]};
        if (!pre_accepted) begin
            valid = 1'b1;
            value = vec;
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL xfer_ready_at_accept: ready=%b want 1", ready);
        end
        miso_pat[0] = p0;
        miso_pat[1] = p1;
        frame_base  = cs_falls;
        @(posedge CLK); #1;
        if (!hold) begin
            valid = 1'b0;
            value = NC*DW'($urandom);
        end
        for (int t = 1; t <= last + 1; t++) begin
            if (hold && t == 10) value = vec_next;
            model(t, NC, FW, DIV, GAP, cs, sck, fr, bi, dn, rv);
            mo = (cs == 1'b0) ? fr_exp[fr][FW-1-bi] : 1'b0;
            n_checks++;
            if ({CS_n, SCK, MOSI, done, rvalid, ready} !== {cs, sck, mo, dn, rv, (t == last + 1)}) begin
                n_fail++;
                $display("FAIL xfer_pins t=%0d: {cs,sck,mosi,done,rv,rdy}=%b want %b", t,
                         {CS_n, SCK, MOSI, done, rvalid, ready}, {cs, sck, mo, dn, rv, (t == last + 1)});
            end
            if (rv) begin
                n_checks++;
                if (rdata !== miso_pat[fr]) begin
                    n_fail++;
                    $display("FAIL xfer_rdata t=%0d frame %0d: rdata=%h want %h", t, fr, rdata, miso_pat[fr]);
                end
            end
            if (t <= last) begin
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic test_midframe_reset();
        logic [NC*DW-1:0] vec;
        vec = NC*DW'({$urandom, $urandom});
        valid = 1'b1;
        value = vec;
        frame_base = cs_falls;
        @(posedge CLK); #1;
        valid = 1'b0;
        for (int t = 1; t < 40; t++) begin
            @(posedge CLK); #1;
        end
        n_checks++;
        if (CS_n !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_active: CS_n=%b want 0 at cycle 40", CS_n);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if ({CS_n, SCK, MOSI, done, rvalid, ready} !== 6'b100000) begin
            n_fail++;
            $display("FAIL midreset_abort: {cs,sck,mosi,done,rv,rdy}=%b want 100000",
                     {CS_n, SCK, MOSI, done, rvalid, ready});
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(posedge CLK); #1;
            n_checks++;
            if ({CS_n, done, rvalid} !== 3'b100) begin
                n_fail++;
                $display("FAIL midreset_no_resume +%0d: {cs,done,rv}=%b want 100", t, {CS_n, done, rvalid});
            end
        end
    endtask

    task automatic test_config_sweep();
        logic [FW1-1:0] f1;
        logic cs, sck, dn, rv, mo;
        int fr, bi;
        for (int k = 0; k < 2; k++) begin
            value1 = (k == 0) ? 12'hFFF : 12'($urandom);
            f1 = {1'b0, value1};
            valid1 = 1'b1;
            n_checks++;
            if (ready1 !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_ready: ready1=%b want 1", ready1);
            end
            @(posedge CLK); #1;
            valid1 = 1'b0;
            for (int t = 1; t <= 28; t++) begin
                model(t, 1, FW1, 1, GAP, cs, sck, fr, bi, dn, rv);
                mo = (cs == 1'b0) ? f1[FW1-1-bi] : 1'b0;
                n_checks++;
                if ({CS_n1, SCK1, MOSI1, done1, rvalid1, ready1} !== {cs, sck, mo, dn, rv, (t == 28)}) begin
                    n_fail++;
                    $display("FAIL sweep_pins t=%0d: {cs,sck,mosi,done,rv,rdy}=%b want %b", t,
                             {CS_n1, SCK1, MOSI1, done1, rvalid1, ready1}, {cs, sck, mo, dn, rv, (t == 28)});
                end
                if (rv) begin
                    n_checks++;
                    if (rdata1 !== 13'h1FFF) begin
                        n_fail++;
                        $display("FAIL sweep_rdata: rdata1=%h want 1fff", rdata1);
                    end
                end
                if (t < 28) begin
                    @(posedge CLK); #1;
                end
            end
        end
    endtask

    initial begin
        logic [NC*DW-1:0] va, vb;
        logic [FW-1:0] pa, pb;
        test_reset();
        test_transfer(32'hBEEF1234, 20'hA5A5A, FW'($urandom), 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            test_transfer(NC*DW'($urandom), FW'($urandom), FW'($urandom), 1'b0, 1'b0, '0);
        end
        va = NC*DW'($urandom);
        vb = ~va;
        pa = FW'($urandom);
        pb = FW'($urandom);
        test_transfer(va, pa, pb, 1'b0, 1'b1, vb);
        test_transfer(vb, pa, pb, 1'b1, 1'b0, '0);
        test_midframe_reset();
        test_transfer(NC*DW'($urandom), FW'($urandom), FW'($urandom), 1'b0, 1'b0, '0);
        test_config_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
